frv_divider: RTL and testbench

Iterative multi-cycle integer divide/remainder unit for the execute stage. It runs alongside the single-cycle ALU and takes the same operand pair. It implements RISC-V DIV, DIVU, REM and REMU with a restoring, one-bit-per-cycle algorithm and a fixed latency. The pipeline holds the request until the unit pulses ready, and can abort it with a flush.

---
 rtl/frv_divider.sv | 226 ++++++++++++++++++++++
 tb/tb_frv_divider.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_divider.sv
// frv_divider: iterative restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Operands are latched on request and converted to magnitudes for signed
// ops. One quotient bit is produced per cycle for XLEN cycles. The sign
// correction is applied when the result register is loaded. Latency is fixed
// at 33 cycles from request to the ready pulse.
module frv_divider #(
  parameter int XLEN = 32,
  localparam int XL  = XLEN - 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        div_valid,
  input  logic        div_op_div,
  input  logic        div_op_divu,
  input  logic        div_op_rem,
  input  logic        div_op_remu,
  input  logic [XL:0] div_rs1,
  input  logic [XL:0] div_rs2,
  output logic        div_ready,
  output logic [XL:0] div_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's complement negation, mod 2^XLEN.
  function automatic logic [XL:0] neg_f(input logic [XL:0] x);
    return (~x) + {{XL{1'b0}}, 1'b1};
  endfunction

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] count_r;
  logic [XL:0]   q_r;
  logic [XLEN:0] rem_r;
  logic [XL:0]   divisor_r;
  logic          op_div_r;
  logic          op_divu_r;
  logic          op_rem_r;
  logic          op_remu_r;
  logic          neg_q_r;
  logic          neg_r_r;
  logic          div0_r;
  logic [XL:0]   result_r;
  logic          ready_r;

  logic          signed_op_s;
  logic          rs1_neg_s;
  logic          rs2_neg_s;
  logic [XL:0]   rs1_mag_s;
  logic [XL:0]   rs2_mag_s;
  logic [XLEN:0] rem_shift_s;
  logic [XLEN:0] rem_sub_s;
  logic          take_s;
  logic [XLEN:0] rem_step_s;
  logic [XL:0]   q_step_s;
  logic          last_s;
  logic [XL:0]   result_s;

  // Operand conditioning: signed ops work on magnitudes.
  always_comb begin
    signed_op_s = div_op_div | div_op_rem;
    rs1_neg_s   = signed_op_s & div_rs1[XL];
    rs2_neg_s   = signed_op_s & div_rs2[XL];
    if (rs1_neg_s) begin
      rs1_mag_s = neg_f(div_rs1);
    end else begin
      rs1_mag_s = div_rs1;
    end
    if (rs2_neg_s) begin
      rs2_mag_s = neg_f(div_rs2);
    end else begin
      rs2_mag_s = div_rs2;
    end
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // A set top remainder bit would already exceed any divisor, so it forces a take.
  always_comb begin
    rem_shift_s = {rem_r[XL:0], q_r[XL]};
    rem_sub_s   = rem_shift_s - {1'b0, divisor_r};
    take_s      = rem_r[XLEN] | (rem_shift_s >= {1'b0, divisor_r});
    if (take_s) begin
      rem_step_s = rem_sub_s;
    end else begin
      rem_step_s = rem_shift_s;
    end
    q_step_s = {q_r[XL-1:0], take_s};
    last_s   = (state_r == ST_RUN) && (count_r == CW'(XL));
  end

  // Final result selection and sign correction from the last step's values.
  // A zero divisor leaves the quotient all ones, which must not be negated.
  always_comb begin
    result_s = {XLEN{1'b0}};
    if (op_divu_r) begin
      result_s = q_step_s;
    end else if (op_remu_r) begin
      result_s = rem_step_s[XL:0];
    end else if (op_div_r) begin
      if (neg_q_r && !div0_r) begin
        result_s = neg_f(q_step_s);
      end else begin
        result_s = q_step_s;
      end
    end else if (op_rem_r) begin
      if (neg_r_r) begin
        result_s = neg_f(rem_step_s[XL:0]);
      end else begin
        result_s = rem_step_s[XL:0];
      end
    end else begin
      result_s = {XLEN{1'b0}};
    end
  end

  // Next-state logic; flush wins over a new request in every state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else if (div_valid) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch on request acceptance and iteration of the datapath in RUN.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      count_r   <= {CW{1'b0}};
      q_r       <= {XLEN{1'b0}};
      rem_r     <= {(XLEN+1){1'b0}};
      divisor_r <= {XLEN{1'b0}};
      op_div_r  <= 1'b0;
      op_divu_r <= 1'b0;
      op_rem_r  <= 1'b0;
      op_remu_r <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      div0_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (div_valid && !flush) begin
            count_r   <= {CW{1'b0}};
            q_r       <= rs1_mag_s;
            rem_r     <= {(XLEN+1){1'b0}};
            divisor_r <= rs2_mag_s;
            op_div_r  <= div_op_div;
            op_divu_r <= div_op_divu;
            op_rem_r  <= div_op_rem;
            op_remu_r <= div_op_remu;
            neg_q_r   <= rs1_neg_s ^ rs2_neg_s;
            neg_r_r   <= rs1_neg_s;
            div0_r    <= (div_rs2 == {XLEN{1'b0}});
          end else begin
            count_r <= count_r;
          end
        end
        ST_RUN: begin
          count_r <= count_r + CW'(1);
          q_r     <= q_step_s;
          rem_r   <= rem_step_s;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Result loads on the final iteration (even when flushed); ready mirrors entry into DONE.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      result_r <= {XLEN{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (last_s) begin
        result_r <= result_s;
      end else begin
        result_r <= result_r;
      end
      ready_r <= (state_next_s == ST_DONE);
    end
  end

  assign div_ready  = ready_r;
  assign div_result = result_r;

endmodule

// File: tb/tb_frv_divider.sv
// Self-checking bench for frv_divider: directed boundary cases, flush and
// reset scenarios, back-to-back requests, then randomized operations
// against an arithmetic reference model.
module tb_frv_divider;

  localparam int OP_DIV  = 0;
  localparam int OP_DIVU = 1;
  localparam int OP_REM  = 2;
  localparam int OP_REMU = 3;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        flush;
  logic        div_valid;
  logic        div_op_div;
  logic        div_op_divu;
  logic        div_op_rem;
  logic        div_op_remu;
  logic [31:0] div_rs1;
  logic [31:0] div_rs2;
  logic        div_ready;
  logic [31:0] div_result;

  int n_cmp = 0;
  int n_err = 0;

  frv_divider #(.XLEN(32)) dut (
    .g_clk       (g_clk),
    .g_resetn    (g_resetn),
    .flush       (flush),
    .div_valid   (div_valid),
    .div_op_div  (div_op_div),
    .div_op_divu (div_op_divu),
    .div_op_rem  (div_op_rem),
    .div_op_remu (div_op_remu),
    .div_rs1     (div_rs1),
    .div_rs2     (div_rs2),
    .div_ready   (div_ready),
    .div_result  (div_result)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics written directly as arithmetic.
  function automatic logic [31:0] ref_model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    case (op)
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sr = sa / sb;
        return sr;
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sr = sa % sb;
        return sr;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
    @(posedge g_clk);
    #1;
    div_valid   = 1'b1;
    div_op_div  = (op == OP_DIV);
    div_op_divu = (op == OP_DIVU);
    div_op_rem  = (op == OP_REM);
    div_op_remu = (op == OP_REMU);
    div_rs1     = a;
    div_rs2     = b;
  endtask

  // Issue one op, optionally flushing in cycle flush_at (0 = none).
  // Returns the cycle offset of the first ready pulse (0 if none) and the
  // result value seen before the request.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int lat, output logic [31:0] prior);
    issue(op, a, b);
    prior = div_result;
    lat   = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge g_clk);
      #1;
      if (i == flush_at) begin
        flush     = 1'b1;
        div_valid = 1'b0;
      end else begin
        flush = 1'b0;
      end
      if (div_ready && lat == 0) lat = i;
      if (i == 32 && flush_at == 0) chk("result_hold_run", div_result, prior);
      if (i == 34) chk("ready_one_cycle", {31'd0, div_ready}, 32'd0);
      if (i == 33) div_valid = 1'b0;
    end
  endtask

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t        dir_vecs[$];
  int          lat;
  int          t1;
  int          t2;
  logic [31:0] prior;
  logic [31:0] exp_v;
  logic [31:0] ra;
  logic [31:0] rb;
  int          rop;

  initial begin
    g_resetn    = 1'b0;
    flush       = 1'b0;
    div_valid   = 1'b0;
    div_op_div  = 1'b0;
    div_op_divu = 1'b0;
    div_op_rem  = 1'b0;
    div_op_remu = 1'b0;
    div_rs1     = 32'd0;
    div_rs2     = 32'd0;
    #12;
    chk("reset_ready", {31'd0, div_ready}, 32'd0);
    chk("reset_result", div_result, 32'd0);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;

    dir_vecs.push_back('{OP_DIVU, 32'd100, 32'd7});
    dir_vecs.push_back('{OP_REMU, 32'd100, 32'd7});
    dir_vecs.push_back('{OP_DIV,  32'hFFFF_FFF9, 32'd2});
    dir_vecs.push_back('{OP_REM,  32'hFFFF_FFF9, 32'd2});
    dir_vecs.push_back('{OP_REM,  32'd7, 32'hFFFF_FFFE});
    dir_vecs.push_back('{OP_DIV,  32'h1234_5678, 32'd0});
    dir_vecs.push_back('{OP_DIVU, 32'h1234_5678, 32'd0});
    dir_vecs.push_back('{OP_REM,  32'h1234_5678, 32'd0});
    dir_vecs.push_back('{OP_REMU, 32'h1234_5678, 32'd0});
    dir_vecs.push_back('{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF});
    dir_vecs.push_back('{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF});
    dir_vecs.push_back('{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF});

    foreach (dir_vecs[k]) begin
      run_op(dir_vecs[k].op, dir_vecs[k].a, dir_vecs[k].b, 0, lat, prior);
      chk("dir_latency", lat, 32'd33);
      chk("dir_result", div_result, ref_model(dir_vecs[k].op, dir_vecs[k].a, dir_vecs[k].b));
    end

    // Spot-check the model itself on the published values.
    chk("spec_divu_100_7", ref_model(OP_DIVU, 32'd100, 32'd7), 32'd14);
    chk("spec_div_m7_2", ref_model(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);

    // Flush mid-run: no ready, result unchanged; then a fresh DIVU 9/3.
    run_op(OP_DIV, 32'd1000, 32'd7, 10, lat, prior);
    chk("flush_no_ready", lat, 32'd0);
    chk("flush_result_hold", div_result, prior);
    run_op(OP_DIVU, 32'd9, 32'd3, 0, lat, prior);
    chk("after_flush_latency", lat, 32'd33);
    chk("after_flush_result", div_result, 32'd3);

    // Flush in the last RUN cycle: result loads, no ready pulse.
    run_op(OP_REMU, 32'd55, 32'd10, 32, lat, prior);
    chk("flush_last_no_ready", lat, 32'd0);
    chk("flush_last_result", div_result, 32'd5);

    // Flush in DONE: the pulse is still driven.
    run_op(OP_DIVU, 32'd77, 32'd11, 33, lat, prior);
    chk("flush_done_ready", lat, 32'd33);
    chk("flush_done_result", div_result, 32'd7);

    // valid held through N+34 starts a second op, ready again at N+67.
    issue(OP_DIVU, 32'd1000, 32'd10);
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 75; i++) begin
      @(posedge g_clk);
      #1;
      if (div_ready) begin
        if (t1 == 0) t1 = i;
        else if (t2 == 0) t2 = i;
      end
      if (i == 67) div_valid = 1'b0;
    end
    chk("b2b_first", t1, 32'd33);
    chk("b2b_second", t2, 32'd67);
    chk("b2b_result", div_result, 32'd100);

    // Asynchronous reset mid-run.
    issue(OP_DIVU, 32'd500, 32'd5);
    for (int i = 1; i <= 15; i++) begin
      @(posedge g_clk);
      #1;
    end
    g_resetn  = 1'b0;
    div_valid = 1'b0;
    #1;
    chk("rst_mid_ready", {31'd0, div_ready}, 32'd0);
    chk("rst_mid_result", div_result, 32'd0);
    #3;
    g_resetn = 1'b1;
    t1 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge g_clk);
      #1;
      if (div_ready) t1 = i;
    end
    chk("rst_stay_idle", t1, 32'd0);
    chk("rst_result_hold", div_result, 32'd0);

    // Randomized ops with biased divisors and dividends.
    for (int n = 0; n < 150; n++) begin
      rop = $urandom_range(0, 3);
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        3:       rb = ~$urandom_range(0, 15);
        default: rb = $urandom;
      endcase
      exp_v = ref_model(rop, ra, rb);
      run_op(rop, ra, rb, 0, lat, prior);
      chk("rand_latency", lat, 32'd33);
      chk("rand_result", div_result, exp_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
